// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the IMEM boot loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word shift register; word_full pulses the cycle after the 4th byte.
// One byte per cycle when byte_vld; clr discards any partial word.
module imem_word_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word_dat,
  output logic [1:0]  byte_cnt,
  output logic        word_full
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        full_q, full_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    full_d = 1'b0;
    if (clr) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (byte_vld) begin
      // Shift in from the top so byte 0 lands in [7:0] after four bytes.
      word_d = {byte_dat, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
      full_d = (cnt_q == LAST_BYTE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign word_dat  = word_q;
  assign byte_cnt  = cnt_q;
  assign word_full = full_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader into IMEM; holds the core in reset while loading.
// Optional trailing XOR checksum byte when BOOT_CHECKSUM_EN is defined.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter int         DEPTH_IMEM = 64,
  parameter logic [7:0] MAGIC      = MAGIC_DEFAULT,
  localparam int        AW         = $clog2(DEPTH_IMEM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             imem_we,
  output logic [AW-1:0]    imem_addr,
  output logic [WIDTH-1:0] imem_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             error
);

`ifdef BOOT_CHECKSUM_EN
  localparam state_t AFTER_DATA = ST_CSUM;
`else
  localparam state_t AFTER_DATA = ST_DONE;
`endif

  state_t        state_q, state_d;
  logic          rdy_en_q, rdy_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   count_q, count_d;

  logic          rx_fire, is_magic, restart, last_word;
  logic          pk_vld, word_full;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_dat;

  assign rx_fire   = rx_valid && rx_ready;
  assign is_magic  = (rx_data == MAGIC);
  assign restart   = rx_fire && is_magic &&
                     (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  assign pk_vld    = rx_fire && (state_q == ST_DATA);
  assign last_word = ((16'(addr_q) + 16'd1) == count_q);

  imem_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (restart),
    .byte_vld  (pk_vld),
    .byte_dat  (rx_data),
    .word_dat  (word_dat),
    .byte_cnt  (byte_cnt),
    .word_full (word_full)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (restart) begin
      csum_d = '0;
    end else if (rx_fire && (state_q == ST_LEN_LO || state_q == ST_LEN_HI ||
                             state_q == ST_DATA)) begin
      csum_d = csum_q ^ rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    rdy_en_d = 1'b1;
    addr_d   = addr_q;
    len_lo_d = len_lo_q;
    count_d  = count_q;
    if (restart) addr_d = '0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (restart) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (rx_fire) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_fire) begin
          count_d = {rx_data, len_lo_q};
          if ({rx_data, len_lo_q} > 16'(DEPTH_IMEM)) state_d = ST_ERR;
          else if ({rx_data, len_lo_q} == 16'd0)     state_d = AFTER_DATA;
          else                                       state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pk_vld && byte_cnt == 2'(BYTES_PER_WORD - 1)) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Address holds on the last word so a full-depth frame never wraps.
        if (last_word) begin
          state_d = AFTER_DATA;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = ST_DATA;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_fire) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
      addr_q   <= '0;
      len_lo_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= rdy_en_d;
      addr_q   <= addr_d;
      len_lo_q <= len_lo_d;
      count_q  <= count_d;
    end
  end

  assign rx_ready   = rdy_en_q && (state_q != ST_WRITE);
  assign imem_we    = (state_q == ST_WRITE) && word_full;
  assign imem_addr  = addr_q;
  assign imem_wdata = word_dat[WIDTH-1:0];
  assign cpu_rst    = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; checksum scenario active when BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [64];
  logic [5:0]  wr_log [64];
  int          wr_cnt = 0;
  logic [31:0] words [$];

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  // Write monitor: captures every strobe and checks input is stalled during it.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      vectors++;
      if (rx_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL rdy_during_write: rx_ready=%b required 0", rx_ready);
      end
      mem[imem_addr] = imem_wdata;
      if (wr_cnt < 64) wr_log[wr_cnt] = imem_addr;
      wr_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_sb();
    wr_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEADBEEF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int n = 0; n < 200; n++) begin
      if (rx_ready === 1'b1) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1 rx_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_timeout: byte %h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_frame(input int gap, input bit bad_csum);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [31:0] w;
    logic [7:0]  b;
    n  = 16'(words.size());
    cs = n[7:0] ^ n[15:8];
    send_byte(8'hA5, gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        b  = w[8*k +: 8];
        cs = cs ^ b;
        send_byte(b, gap);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, gap);
`else
    if (bad_csum) $display("note: checksum not built in");
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    vectors++; if (rx_ready !== 1'b0)      begin miscompares++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    vectors++; if (imem_we !== 1'b0)       begin miscompares++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
    vectors++; if (imem_addr !== 6'd0)     begin miscompares++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    vectors++; if (imem_wdata !== 32'd0)   begin miscompares++; $display("FAIL reset_imem_wdata: got %h want 0", imem_wdata); end
    vectors++; if (cpu_rst !== 1'b1)       begin miscompares++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
    vectors++; if (done !== 1'b0)          begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (error !== 1'b0)         begin miscompares++; $display("FAIL reset_error: got %b want 0", error); end
    rst = 1'b0;
    #1;
    vectors++; if (rx_ready !== 1'b0)      begin miscompares++; $display("FAIL first_cycle_rdy: got %b want 0", rx_ready); end
    @(negedge clk);
    vectors++; if (rx_ready !== 1'b1)      begin miscompares++; $display("FAIL second_cycle_rdy: got %b want 1", rx_ready); end
  endtask

  task automatic check_two_word(input string tag);
    vectors++; if (wr_cnt !== 2)                begin miscompares++; $display("FAIL %s_wr_cnt: got %0d want 2", tag, wr_cnt); end
    vectors++; if (wr_log[0] !== 6'd0 || wr_log[1] !== 6'd1)
                                                begin miscompares++; $display("FAIL %s_addr_seq: got %0d,%0d want 0,1", tag, wr_log[0], wr_log[1]); end
    vectors++; if (mem[0] !== 32'h00100513)     begin miscompares++; $display("FAIL %s_mem0: got %h want 00100513", tag, mem[0]); end
    vectors++; if (mem[1] !== 32'h0000006F)     begin miscompares++; $display("FAIL %s_mem1: got %h want 0000006f", tag, mem[1]); end
    vectors++; if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0)
                                                begin miscompares++; $display("FAIL %s_status: got done=%b cpu_rst=%b error=%b want 1 0 0", tag, done, cpu_rst, error); end
  endtask

  task automatic test_basic_frame();
    clear_sb();
    words = '{32'h00100513, 32'h0000006F};
    send_frame(0, 1'b0);
    settle();
    check_two_word("basic");
  endtask

  task automatic test_idle_junk();
    do_reset();
    clear_sb();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    settle();
    vectors++; if (done !== 1'b0 || error !== 1'b0 || cpu_rst !== 1'b1 || wr_cnt !== 0)
      begin miscompares++; $display("FAIL junk_idle: got done=%b error=%b cpu_rst=%b writes=%0d want 0 0 1 0", done, error, cpu_rst, wr_cnt); end
    words = '{32'h00100513, 32'h0000006F};
    send_frame(0, 1'b0);
    settle();
    check_two_word("junk");
  endtask

  task automatic test_len_bounds();
    clear_sb();
    send_byte(8'hA5, 0);
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    settle();
    vectors++; if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || wr_cnt !== 0)
      begin miscompares++; $display("FAIL len65: got error=%b cpu_rst=%b done=%b writes=%0d want 1 1 0 0", error, cpu_rst, done, wr_cnt); end
    words.delete();
    send_frame(0, 1'b0);
    settle();
    vectors++; if (error !== 1'b0 || done !== 1'b1 || cpu_rst !== 1'b0 || wr_cnt !== 0)
      begin miscompares++; $display("FAIL len0: got error=%b done=%b cpu_rst=%b writes=%0d want 0 1 0 0", error, done, cpu_rst, wr_cnt); end
    clear_sb();
    words.delete();
    for (int i = 0; i < 64; i++) words.push_back(32'h5A000000 + 32'(i) * 32'h00010203);
    send_frame(0, 1'b0);
    settle();
    vectors++; if (wr_cnt !== 64)               begin miscompares++; $display("FAIL len64_cnt: got %0d want 64", wr_cnt); end
    vectors++; if (wr_log[63] !== 6'd63)        begin miscompares++; $display("FAIL len64_last_addr: got %0d want 63", wr_log[63]); end
    vectors++; if (mem[63] !== 32'h5A3F7EBD)    begin miscompares++; $display("FAIL len64_mem63: got %h want 5a3f7ebd", mem[63]); end
    vectors++; if (mem[0] !== 32'h5A000000)     begin miscompares++; $display("FAIL len64_mem0: got %h want 5a000000", mem[0]); end
    vectors++; if (done !== 1'b1 || error !== 1'b0)
      begin miscompares++; $display("FAIL len64_status: got done=%b error=%b want 1 0", done, error); end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    clear_sb();
    words = '{32'h00100513, 32'h0000006F};
    send_frame(0, 1'b1);
    settle();
    vectors++; if (wr_cnt !== 2 || mem[0] !== 32'h00100513 || mem[1] !== 32'h0000006F)
      begin miscompares++; $display("FAIL csum_bad_writes: got %0d %h %h want 2 00100513 0000006f", wr_cnt, mem[0], mem[1]); end
    vectors++; if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0)
      begin miscompares++; $display("FAIL csum_bad_status: got error=%b cpu_rst=%b done=%b want 1 1 0", error, cpu_rst, done); end
    clear_sb();
    send_frame(0, 1'b0);
    settle();
    check_two_word("csum_good");
  endtask
`endif

  task automatic test_reset_mid_frame();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    do_reset();
    clear_sb();
    words = '{32'hCAFEF00D};
    send_frame(0, 1'b0);
    settle();
    vectors++; if (wr_cnt !== 1 || mem[0] !== 32'hCAFEF00D)
      begin miscompares++; $display("FAIL rst_mid: got writes=%0d mem0=%h want 1 cafef00d", wr_cnt, mem[0]); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rst_mid_done: got %b want 1", done); end
  endtask

  task automatic test_restart();
    clear_sb();
    send_byte(8'hA5, 0);
    vectors++; if (cpu_rst !== 1'b1 || done !== 1'b0)
      begin miscompares++; $display("FAIL restart_cpu_rst: got cpu_rst=%b done=%b want 1 0", cpu_rst, done); end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h01 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12, 0);
`endif
    settle();
    vectors++; if (wr_cnt !== 1 || wr_log[0] !== 6'd0 || mem[0] !== 32'h12345678)
      begin miscompares++; $display("FAIL restart_write: got writes=%0d addr=%0d data=%h want 1 0 12345678", wr_cnt, wr_log[0], mem[0]); end
    vectors++; if (done !== 1'b1 || cpu_rst !== 1'b0)
      begin miscompares++; $display("FAIL restart_done: got done=%b cpu_rst=%b want 1 0", done, cpu_rst); end
    clear_sb();
    words = '{32'h12345678};
    send_frame(3, 1'b0);
    settle();
    vectors++; if (wr_cnt !== 1 || wr_log[0] !== 6'd0 || mem[0] !== 32'h12345678)
      begin miscompares++; $display("FAIL gaps_write: got writes=%0d addr=%0d data=%h want 1 0 12345678", wr_cnt, wr_log[0], mem[0]); end
    vectors++; if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0)
      begin miscompares++; $display("FAIL gaps_done: got done=%b cpu_rst=%b error=%b want 1 0 0", done, cpu_rst, error); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_idle_junk();
    test_len_bounds();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_frame();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
